// File: rtl/vend_pkg.sv
// Shared types and coin encoding for the vending transaction controller.
package vend_pkg;

    localparam int CREDIT_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        VEND    = 3'd2,
        CHANGE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W-1:0] v;
        case (code)
            COIN_1:  v = CREDIT_W'(1);
            COIN_2:  v = CREDIT_W'(2);
            COIN_5:  v = CREDIT_W'(5);
            default: v = CREDIT_W'(10);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_change_sub.sv
// Change-subtract datapath: paid minus zero-extended price.
module vend_change_sub #(
    parameter int CREDIT_W = 5,
    parameter int PRICE_W  = 4
) (
    input  logic [CREDIT_W-1:0] paid,
    input  logic [PRICE_W-1:0]  price,
    output logic [CREDIT_W-1:0] change
);

    assign change = paid - CREDIT_W'(price);

endmodule

// File: rtl/vend_change_ctrl.sv
// Vending transaction controller: credit accumulation, selection check,
// and greedy one-coin-per-handshake change payout.
module vend_change_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 5,
    parameter int PRICE_W    = 4,
    parameter int MAX_CREDIT = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                sel_valid,
    input  logic [PRICE_W-1:0]  sel_price,
    input  logic                cancel,
    input  logic                coin_out_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                insufficient,
    output logic                vend_pulse,
    output logic                coin_out_valid,
    output logic [1:0]          coin_out_val,
    output logic                busy,
    output logic                done
);

    state_t              state;
    logic [CREDIT_W-1:0] remaining;
    logic [CREDIT_W-1:0] change_w;
    logic [CREDIT_W-1:0] coin_in_w;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] rem_next;
    logic                price_ok;

    vend_change_sub #(
        .CREDIT_W (CREDIT_W),
        .PRICE_W  (PRICE_W)
    ) u_change (
        .paid   (credit),
        .price  (sel_price),
        .change (change_w)
    );

    // Largest coin not exceeding the amount still owed.
    function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] r);
        logic [1:0] c;
        if (r >= CREDIT_W'(10))      c = COIN_10;
        else if (r >= CREDIT_W'(5))  c = COIN_5;
        else if (r >= CREDIT_W'(2))  c = COIN_2;
        else                         c = COIN_1;
        return c;
    endfunction

    assign coin_in_w = CREDIT_W'(coin_value(coin_val));
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_in_w};
    assign price_ok  = credit >= CREDIT_W'(sel_price);
    assign rem_next  = remaining - CREDIT_W'(coin_value(coin_out_val));

    // Change port handshake: coin_out_valid/coin_out_val are registered and
    // held unchanged until a rising edge sees coin_out_valid && coin_out_ready;
    // that edge retires the coin and presents the next one (or drops valid).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            credit         <= '0;
            remaining      <= '0;
            coin_reject    <= 1'b0;
            insufficient   <= 1'b0;
            vend_pulse     <= 1'b0;
            coin_out_valid <= 1'b0;
            coin_out_val   <= 2'b00;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            vend_pulse   <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (cancel) begin
                        coin_reject    <= coin_valid;
                        remaining      <= credit;
                        coin_out_valid <= credit != '0;
                        coin_out_val   <= pick_coin(credit);
                        busy           <= 1'b1;
                        state          <= CHANGE;
                    end else if (sel_valid) begin
                        coin_reject <= coin_valid;
                        if (price_ok) begin
                            remaining  <= change_w;
                            vend_pulse <= 1'b1;
                            busy       <= 1'b1;
                            state      <= VEND;
                        end else begin
                            insufficient <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                            credit <= coin_sum[CREDIT_W-1:0];
                            state  <= COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    coin_reject    <= coin_valid;
                    coin_out_valid <= remaining != '0;
                    coin_out_val   <= pick_coin(remaining);
                    state          <= CHANGE;
                end
                CHANGE: begin
                    coin_reject <= coin_valid;
                    if (remaining == '0) begin
                        coin_out_valid <= 1'b0;
                        done           <= 1'b1;
                        state          <= DONE;
                    end else if (coin_out_valid && coin_out_ready) begin
                        remaining      <= rem_next;
                        coin_out_valid <= rem_next != '0;
                        coin_out_val   <= pick_coin(rem_next);
                    end
                end
                DONE: begin
                    coin_reject <= coin_valid;
                    credit      <= '0;
                    remaining   <= '0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Directed and randomized bench for vend_change_ctrl against a transaction-level model.
module tb_vend_change_ctrl;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic       sel_valid;
    logic [3:0] sel_price;
    logic       cancel;
    logic       coin_out_ready;
    logic [4:0] credit;
    logic       coin_reject;
    logic       insufficient;
    logic       vend_pulse;
    logic       coin_out_valid;
    logic [1:0] coin_out_val;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int credit_m = 0;
    logic [1:0] exp_q[$];

    vend_change_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_val       (coin_val),
        .sel_valid      (sel_valid),
        .sel_price      (sel_price),
        .cancel         (cancel),
        .coin_out_ready (coin_out_ready),
        .credit         (credit),
        .coin_reject    (coin_reject),
        .insufficient   (insufficient),
        .vend_pulse     (vend_pulse),
        .coin_out_valid (coin_out_valid),
        .coin_out_val   (coin_out_val),
        .busy           (busy),
        .done           (done)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_amount(input logic [1:0] code);
        case (code)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 5;
            default: return 10;
        endcase
    endfunction

    // Expected greedy payout for an amount, as coin codes in order.
    function automatic void load_change(input int amt);
        int denom[4];
        logic [1:0] code[4];
        denom = '{10, 5, 2, 1};
        code  = '{2'b11, 2'b10, 2'b01, 2'b00};
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            while (amt >= denom[i]) begin
                exp_q.push_back(code[i]);
                amt -= denom[i];
            end
        end
    endfunction

    // Service the change port until done; ready held low for the first `hold` cycles.
    task automatic payout(input int hold, input bit rand_ready);
        logic [1:0] got[$];
        logic [1:0] prev;
        bit pending;
        bit seen_done;
        bit r;
        int cyc;
        int extra_vend;
        int n;
        pending = 0; seen_done = 0; cyc = 0; extra_vend = 0; prev = 2'b00;
        while (!seen_done && cyc < 400) begin
            if (done === 1'b1) begin
                seen_done = 1;
                chk("valid_low_at_done", coin_out_valid, 0);
            end else begin
                if (cyc > 0 && vend_pulse === 1'b1) extra_vend++;
                if (coin_out_valid === 1'b1) begin
                    if (pending) chk("coin_out_val_stable", coin_out_val, prev);
                    r = (cyc >= hold) && (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
                    coin_out_ready = r;
                    if (r) got.push_back(coin_out_val);
                    pending = !r;
                    prev = coin_out_val;
                end else begin
                    coin_out_ready = 1'($urandom_range(0, 1));
                    pending = 0;
                end
                step();
                cyc++;
            end
        end
        coin_out_ready = 1'b0;
        chk("done_seen", seen_done, 1);
        chk("vend_pulse_once", extra_vend, 0);
        chk("coin_count", got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("coin_%0d", i), got[i], exp_q[i]);
        step();
        credit_m = 0;
        chk("done_one_cycle", done, 0);
        chk("credit_cleared", credit, credit_m);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic do_coin(input logic [1:0] v);
        int amt;
        logic exp_rej;
        amt = coin_amount(v);
        coin_valid = 1'b1;
        coin_val = v;
        step();
        coin_valid = 1'b0;
        if (credit_m + amt <= 31) begin
            credit_m += amt;
            exp_rej = 1'b0;
        end else begin
            exp_rej = 1'b1;
        end
        chk("coin_reject", coin_reject, exp_rej);
        chk("credit", credit, credit_m);
    endtask

    task automatic do_sel(input int p, input int hold, input bit rand_ready);
        sel_valid = 1'b1;
        sel_price = 4'(p);
        step();
        sel_valid = 1'b0;
        if (credit_m >= p) begin
            chk("vend_pulse", vend_pulse, 1);
            chk("insufficient_on_vend", insufficient, 0);
            chk("busy_in_vend", busy, 1);
            chk("credit_held_vend", credit, credit_m);
            load_change(credit_m - p);
            payout(hold, rand_ready);
        end else begin
            chk("insufficient", insufficient, 1);
            chk("no_vend", vend_pulse, 0);
            chk("credit_unchanged", credit, credit_m);
            chk("not_busy", busy, 0);
            step();
            chk("insufficient_pulse", insufficient, 0);
        end
    endtask

    task automatic do_cancel(input int hold, input bit rand_ready);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_no_vend", vend_pulse, 0);
        chk("cancel_busy", busy, 1);
        chk("cancel_credit_held", credit, credit_m);
        load_change(credit_m);
        payout(hold, rand_ready);
    endtask

    initial begin
        rst_n = 1'b1;
        coin_valid = 1'b0; coin_val = 2'b00;
        sel_valid = 1'b0; sel_price = 4'd0;
        cancel = 1'b0; coin_out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #5;
        chk("reset_outputs", {credit, coin_reject, insufficient, vend_pulse, coin_out_valid,
                              coin_out_val, busy, done}, 0);
        #20 rst_n = 1'b1;
        step();
        chk("reset_credit", credit, 0);

        // 1: 10+10, price 15 -> one 5 coin back
        do_coin(2'b11); do_coin(2'b11);
        do_sel(15, 0, 0);

        // 2: 5+5 price 5, then insufficient with credit 4
        do_coin(2'b10); do_coin(2'b10);
        do_sel(5, 0, 1);
        do_coin(2'b01); do_coin(2'b01);
        do_sel(9, 0, 0);
        do_cancel(0, 0);

        // 3: credit 13 cancelled; coin during payout is rejected
        do_coin(2'b11); do_coin(2'b01); do_coin(2'b00);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("c3_no_vend", vend_pulse, 0);
        chk("c3_busy", busy, 1);
        coin_valid = 1'b1; coin_val = 2'b00; coin_out_ready = 1'b0;
        step();
        coin_valid = 1'b0;
        chk("busy_coin_reject", coin_reject, 1);
        chk("busy_credit_held", credit, 13);
        load_change(13);
        payout(0, 0);

        // 4: ceiling behaviour, then coin + selection together
        do_coin(2'b11); do_coin(2'b11); do_coin(2'b11);
        do_coin(2'b01);
        do_coin(2'b00);
        coin_valid = 1'b1; coin_val = 2'b00; sel_valid = 1'b1; sel_price = 4'd3;
        step();
        coin_valid = 1'b0; sel_valid = 1'b0;
        chk("coin_sel_reject", coin_reject, 1);
        chk("coin_sel_vend", vend_pulse, 1);
        chk("coin_sel_credit", credit, 31);
        load_change(28);
        payout(0, 1);

        // 5: change 7 with ready stalled for 5 cycles
        do_coin(2'b11);
        do_sel(3, 6, 0);

        // edge cases: IDLE select with zero credit, empty cancel, free vend
        do_sel(7, 0, 0);
        do_cancel(0, 0);
        do_coin(2'b10); do_coin(2'b00);
        do_sel(0, 0, 1);

        // 6: reset during payout
        do_coin(2'b11); do_coin(2'b01); do_coin(2'b00);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        coin_out_ready = 1'b0;
        step(); step();
        chk("pre_reset_valid", coin_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_credit", credit, 0);
        chk("async_reset_valid", coin_out_valid, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_all", {coin_reject, insufficient, vend_pulse, coin_out_val, done}, 0);
        step();
        #3 rst_n = 1'b1;
        credit_m = 0;
        step();
        chk("post_reset_credit", credit, 0);
        chk("post_reset_busy", busy, 0);
        do_coin(2'b01);
        do_sel(2, 0, 0);

        // randomized transactions
        for (int t = 0; t < 20; t++) begin
            int nc;
            nc = $urandom_range(1, 4);
            for (int k = 0; k < nc; k++) do_coin(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) < 7) do_sel($urandom_range(0, 15), $urandom_range(0, 3), 1);
            else do_cancel($urandom_range(0, 3), 1);
        end
        if (credit_m != 0) do_cancel(0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
